// File: rtl/dmem_stall_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_stall_ctrl
//
// Multi-cycle data-memory access controller. It sits between the memory port
// of a single-cycle CPU datapath and a slow data memory that uses a req/ack
// handshake. Each load/store is captured and turned into one memory request.
// The CPU is stalled while the request is outstanding. Load data is then
// returned in a single DONE cycle. Misaligned word accesses are flagged and
// never reach memory.
//
// Optional feature (compile-time macro): DMEM_TIMEOUT_EN
//   When defined, a request that waits TIMEOUT cycles in REQ without an
//   acknowledge is aborted. The access completes with err_o=1 and
//   cpu_rdata_o=0, and a late acknowledge is ignored.
//   When undefined, REQ waits for mem_ack_i indefinitely.
//
// Parameters
//   TIMEOUT       maximum number of REQ cycles before an abort (timeout build only)
//
// Ports
//   clk_i         clock, rising edge
//   rst_n         synchronous active-low reset
//   cpu_mread_i   load request (decoder MemRead)
//   cpu_mwrite_i  store request (decoder MemWrite); wins when both are set
//   cpu_addr_i    byte address from the ALU
//   cpu_wdata_i   store data
//   cpu_rdata_o   registered load data, held until the next DONE
//   cpu_stall_o   hold PC / register-file write while 1 (combinational)
//   err_o         one-cycle pulse in DONE: misaligned or timed-out access
//   mem_req_o     memory request, held until acknowledged
//   mem_we_o      1 = write, 0 = read
//   mem_addr_o    latched word address (bits [1:0] always 0)
//   mem_wdata_o   latched store data
//   mem_ack_i     one-cycle completion from memory
//   mem_rdata_i   read data, valid together with mem_ack_i
// -----------------------------------------------------------------------------
module dmem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        cpu_mread_i,
  input  logic        cpu_mwrite_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   access;
  logic   aligned;
  logic   tmo_hit;

  assign access  = cpu_mread_i | cpu_mwrite_i;
  assign aligned = (cpu_addr_i[1:0] == 2'b00);

  // The CPU must not advance while an access is being started or is in
  // flight; DONE is the cycle in which it consumes the result.
  assign cpu_stall_o = ((state == IDLE) && access) || (state == REQ);

`ifdef DMEM_TIMEOUT_EN
  // Counter holds (REQ cycles elapsed - 1); TIMEOUT-1 marks the last cycle
  // the request is allowed to wait.
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != REQ) begin
      // Cleared everywhere outside REQ, so it is zero on entering REQ.
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state == REQ) && (tmo_cnt == TMO_LAST);
`else
  logic timeout_unused;

  assign tmo_hit        = 1'b0;
  assign timeout_unused = (TIMEOUT != 0);
`endif

  // NOTE: rst_n is only looked at on the clock edge (synchronous reset), so
  // it sits inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= IDLE;
      cpu_rdata_o <= '0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all of
      // them update together from the same pre-edge values.
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= cpu_mwrite_i;
              mem_addr_o  <= {cpu_addr_i[31:2], 2'b00};
              mem_wdata_o <= cpu_wdata_i;
              state       <= REQ;
            end else begin
              // Misaligned: never touch memory, report through err_o.
              err_o       <= 1'b1;
              cpu_rdata_o <= '0;
              state       <= DONE;
            end
          end
        end

        REQ: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            cpu_rdata_o <= mem_we_o ? 32'd0 : mem_rdata_i;
            state       <= DONE;
          end else if (tmo_hit) begin
            // Abandon the request; memory is expected to drop it as well.
            mem_req_o   <= 1'b0;
            cpu_rdata_o <= '0;
            err_o       <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          err_o <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_stall_ctrl;

  localparam int unsigned TMO = 8;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_mread;
  logic        cpu_mwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dmem_stall_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .cpu_mread_i  (cpu_mread),
    .cpu_mwrite_i (cpu_mwrite),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_stall_o  (cpu_stall),
    .err_o        (err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected completion of one CPU access (seen in DONE).
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } done_t;

  // Expected memory request plus the ack delay the memory model should use.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
  } req_t;

  done_t       done_q[$];
  req_t        req_q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] mem_arr [64];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Issue one access in the cycle following the current one, record what the
  // DUT must do for it, and wait until it reaches its completion cycle.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay);
    done_t e;
    req_t  r;
    bit    is_wr;
    int    idx;
    int    budget;
    @(posedge clk); #1;
    cpu_mread  = rd;
    cpu_mwrite = wr;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    is_wr      = wr;
    idx        = int'(addr[7:2]);
    if (addr[1:0] != 2'b00) begin
      e = '{rdata: 32'd0, err: 1'b1, stall: 1};
    end else begin
      r = '{we: is_wr, addr: {addr[31:2], 2'b00}, wdata: wdata, delay: delay};
      req_q.push_back(r);
      if (TMO_EN && (delay + 1 > int'(TMO))) begin
        e = '{rdata: 32'd0, err: 1'b1, stall: 1 + int'(TMO)};
      end else begin
        if (is_wr) ref_mem[idx] = wdata;
        e = '{rdata: (is_wr ? 32'd0 : ref_mem[idx]), err: 1'b0, stall: delay + 2};
      end
    end
    done_q.push_back(e);
    budget = 0;
    do begin
      @(posedge clk); #1;
      budget++;
    end while (cpu_stall && budget < 300);
    if (cpu_stall) expire("access_done");
  endtask

  task automatic idle(input int n);
    cpu_mread  = 1'b0;
    cpu_mwrite = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Memory model: answers each new request after its scheduled delay.
  bit   busy = 1'b0;
  int   wait_left = 0;
  req_t cur;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!busy && mem_req === 1'b1) begin
        if (req_q.size() == 0) begin
          expire("unexpected_req");
          cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, delay: 0};
        end else begin
          cur = req_q.pop_front();
        end
        busy      = 1'b1;
        wait_left = cur.delay;
      end
      if (busy && mem_req === 1'b1) begin
        check("req_we",    mem_we,    cur.we);
        check("req_addr",  mem_addr,  cur.addr);
        check("req_wdata", mem_wdata, cur.wdata);
      end
      if (busy) begin
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          busy    = 1'b0;
          // A late ack for an abandoned request must not change memory.
          if (mem_req === 1'b1 && cur.we) mem_arr[cur.addr[7:2]] = cur.wdata;
          if (!cur.we) mem_rdata = mem_arr[cur.addr[7:2]];
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Monitor: a falling cpu_stall marks the DONE cycle of an access.
  bit          prev_stall = 1'b0;
  int          run = 0;
  logic [31:0] held = '0;

  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
        run        = 0;
        held       = '0;
      end else begin
        if (cpu_stall) begin
          run++;
          check("err_while_stalled", err, 1'b0);
          check("rdata_hold", cpu_rdata, held);
        end else if (prev_stall) begin
          if (done_q.size() == 0) begin
            expire("unexpected_done");
          end else begin
            e = done_q.pop_front();
            check("done_rdata", cpu_rdata, e.rdata);
            check("done_err", err, e.err);
            check("stall_cycles", run, e.stall);
            held = e.rdata;
          end
        end else begin
          check("err_idle", err, 1'b0);
          check("rdata_idle_hold", cpu_rdata, held);
        end
        prev_stall = cpu_stall;
        if (!cpu_stall) run = 0;
      end
    end
  end

  initial begin
    int   c0;
    int   kind;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'h9E37_79B1 * (i + 1);
      mem_arr[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    mem_arr[4] = 32'hDEAD_BEEF;

    rst_n      = 1'b0;
    cpu_mread  = 1'b0;
    cpu_mwrite = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_err",   err,       1'b0);
    check("rst_req",   mem_req,   1'b0);
    check("rst_we",    mem_we,    1'b0);
    check("rst_addr",  mem_addr,  32'd0);
    check("rst_wdata", mem_wdata, 32'd0);

    // Directed cases.
    issue(1'b1, 1'b0, 32'h10, 32'h0, 0);
    issue(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4);
    issue(1'b1, 1'b0, 32'h13, 32'h0, 0);
    c0 = cyc;
    issue(1'b1, 1'b0, 32'h0, 32'h0, 0);
    issue(1'b1, 1'b0, 32'h4, 32'h0, 0);
    check("b2b_cycles", cyc - c0, 6);
    issue(1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 1);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 2);
    issue(1'b1, 1'b0, 32'h24, 32'h0, 0);

    // Reset while a request is outstanding.
    idle(1);
    cpu_mread = 1'b1;
    cpu_addr  = 32'h30;
    req_q.push_back('{we: 1'b0, addr: 32'h30, wdata: 32'h0, delay: 6});
    @(posedge clk); #1;
    check("pre_rst_req", mem_req, 1'b1);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    cpu_mread = 1'b0;
    cpu_addr  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_req",   mem_req,   1'b0);
    check("mid_rst_stall", cpu_stall, 1'b0);
    check("mid_rst_err",   err,       1'b0);
    check("mid_rst_rdata", cpu_rdata, 32'd0);
    idle(12);
    check("post_rst_req", mem_req, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // No ack within TMO cycles: abort, then a late ack must be ignored.
    issue(1'b1, 1'b0, 32'h40, 32'h0, 20);
    check("tmo_req_dropped", mem_req, 1'b0);
    idle(30);
    check("tmo_late_req", mem_req, 1'b0);
    check("tmo_late_rdata", cpu_rdata, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom;
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(kind != 1, kind != 0, a, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(10);
    check("done_q_empty", done_q.size(), 0);
    check("req_q_empty",  req_q.size(),  0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_stall_ctrl.md
# dmem_stall_ctrl

Multi-cycle data-memory access controller between the single-cycle CPU datapath's memory port and a slow, handshaked data memory. It captures each load/store the datapath presents and drives a req/ack transaction to memory. While the access is outstanding it stalls the CPU, then returns load data for exactly one cycle. It also flags misaligned word accesses and, optionally, memory timeouts.

## Interface
- TIMEOUT, 255: max cycles in REQ without mem_ack_i before abort (only with DMEM_TIMEOUT_EN)
- clk_i  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- cpu_mread_i  in  1  load request from decoder MemRead
- cpu_mwrite_i  in  1  store request from decoder MemWrite
- cpu_addr_i  in  32  byte address (ALU/shifter result)
- cpu_wdata_i  in  32  store data (rt register)
- cpu_rdata_o  out  32  load data to writeback mux
- cpu_stall_o  out  1  hold PC and register-file write while 1
- err_o  out  1  one-cycle pulse: misaligned or timed-out access
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  latched word address, low 2 bits always 0
- mem_wdata_o  out  32  latched store data
- mem_ack_i  in  1  memory completion, one cycle
- mem_rdata_i  in  32  read data, valid with mem_ack_i

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- Access = cpu_mread_i | cpu_mwrite_i. If both are set, the access is a write and cpu_rdata_o = 0.
- The CPU holds cpu_* inputs stable while cpu_stall_o=1. The controller latches them on the leaving-IDLE edge and ignores later changes.
- IDLE, access, addr[1:0]==0: latch addr, wdata and we; go to REQ.
- IDLE, access, addr[1:0]!=0: no memory request; set error flag; go to DONE.
- IDLE, no access: stay in IDLE.
- REQ, mem_ack_i=1: latch mem_rdata_i (reads only; writes latch 0); go to DONE.
- REQ, no ack: stay in REQ; timeout counter increments.
- DONE: unconditionally return to IDLE.
- cpu_stall_o is combinational: 1 in IDLE when an access is present, 1 in REQ, 0 in DONE and 0 in IDLE with no access.
- cpu_rdata_o is the registered read data and is held until the next DONE. It reads 0 after reset and after any error.
- err_o is 1 only in DONE when the error flag is set. The flag clears on return to IDLE.
- mem_ack_i outside REQ is ignored.

## Timing
- Reset values: cpu_rdata_o=0, cpu_stall_o=0 (no access), err_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, timeout counter=0.
- mem_req_o is registered. It rises on the edge after the CPU presents an access, stays 1 through the ack cycle, and is 0 on the edge after the ack.
- Latency: ack in the first REQ cycle gives 3 cycles per access (2 stalled cycles, then DONE). Each extra wait cycle adds 1.
- The CPU advances (PC update, register write with cpu_rdata_o) on the edge that ends DONE.
- A back-to-back access presented in the cycle after DONE starts a fresh transaction. There are no dead cycles beyond that.
- Misaligned access: 1 stalled cycle, then DONE with err_o=1. mem_req_o never rises.
- rst_n low at any edge, including mid-REQ, forces IDLE and drops mem_req_o at that edge. Memory must discard the abandoned request.

## Configuration
- DMEM_TIMEOUT_EN defined: an 8-bit counter (width sized from TIMEOUT) runs in REQ. When it reaches TIMEOUT with no ack, mem_req_o drops, cpu_rdata_o=0, the error flag is set, and the FSM goes to DONE. A late ack is ignored. The counter clears on entering REQ.
- DMEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for mem_ack_i. err_o reports misalignment only.

## Test plan
- Load, addr=0x10, mem ack 1 cycle after req, rdata=0xDEADBEEF -> stall 2 cycles; DONE with cpu_rdata_o=0xDEADBEEF; err_o=0.
- Store, addr=0x20, wdata=0x12345678, ack delayed 4 cycles -> mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x12345678 held 5 cycles; stall 6 cycles.
- Load, addr=0x13 -> mem_req_o stays 0; stall 1 cycle; DONE err_o=1, cpu_rdata_o=0.
- Two back-to-back loads (0x0, 0x4), ack each in first REQ cycle -> 6 total cycles; two distinct req pulses; rdata returned in order.
- rst_n=0 for one edge while in REQ -> next cycle state IDLE, mem_req_o=0, cpu_stall_o=0 with no access.
- With DMEM_TIMEOUT_EN and TIMEOUT=8, no ack -> mem_req_o drops after 8 REQ cycles; err_o=1 pulse; ack arriving afterward has no effect.
